// File: rtl/zl_dvbs_randomizer_pkg.sv
// Shared constants and types for the DVB-S energy-dispersal randomizer.
// The PRBS seed and polynomial follow the DVB-S 1+x^14+x^15 generator.
package zl_dvbs_randomizer_pkg;

  localparam logic [7:0]  TS_SYNC_BYTE   = 8'h47;
  localparam int          TS_PKT_LEN     = 188;
  localparam logic [15:0] DVBS_PRBS_POLY = 16'hC001;
  localparam logic [14:0] DVBS_PRBS_INIT = 15'h4A80;
  localparam int          DVBS_PKTS_PER_GROUP = 8;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } rnd_state_e;

endpackage

// File: rtl/zl_dvbs_randomizer_lfsr.sv
// Fibonacci LFSR producing PRBS_width bits per step, first generated bit in the MSb.
// State bit [LFSR_width-1] is stage 1 of the serial register; poly bit i taps stage i.
module zl_lfsr #(
  parameter int LFSR_width = 15,
  parameter int PRBS_width = 8,
  parameter logic [LFSR_width:0]   LFSR_poly       = 16'hC001,
  parameter logic [LFSR_width-1:0] LFSR_init_value = 15'h4A80
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  clear,
  output logic [PRBS_width-1:0] prbs
);

  function automatic logic [LFSR_width-1:0] tap_mask(input logic [LFSR_width:0] poly);
    logic [LFSR_width-1:0] m;
    m = '0;
    for (int i = 1; i <= LFSR_width; i++) begin
      m[LFSR_width-i] = poly[i];
    end
    return m;
  endfunction

  localparam logic [LFSR_width-1:0] TAPS = tap_mask(LFSR_poly);

  logic [LFSR_width-1:0] state_r;
  logic [LFSR_width-1:0] state_nxt_s;
  logic [PRBS_width-1:0] prbs_s;
  logic                  fb_s;

  // Unroll PRBS_width serial shifts to get the output byte and the advanced state.
  always_comb begin
    state_nxt_s = state_r;
    prbs_s      = '0;
    fb_s        = 1'b0;
    for (int k = 0; k < PRBS_width; k++) begin
      fb_s = ^(state_nxt_s & TAPS);
      prbs_s[PRBS_width-1-k] = fb_s;
      state_nxt_s = {fb_s, state_nxt_s[LFSR_width-1:1]};
    end
  end

  assign prbs = prbs_s;

  // Register update: clear reloads the seed and wins over advancing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= LFSR_init_value;
    end else if (clear) begin
      state_r <= LFSR_init_value;
    end else if (!stall) begin
      state_r <= state_nxt_s;
    end
  end

endmodule

// File: rtl/zl_dvbs_randomizer.sv
// DVB-S energy dispersal: inverts every 8th sync byte and scrambles payload with the PRBS.
// Single output register stage with valid/ready on both sides.
module zl_dvbs_randomizer
  import zl_dvbs_randomizer_pkg::*;
#(
  parameter logic [15:0] LFSR_poly       = DVBS_PRBS_POLY,
  parameter logic [14:0] LFSR_init_value = DVBS_PRBS_INIT,
  parameter int          PKTS_PER_GROUP  = DVBS_PKTS_PER_GROUP,
  parameter int          PKT_LEN         = TS_PKT_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_sop,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_sop,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       sync_err
);

  localparam int         PKT_CNT_W = (PKTS_PER_GROUP > 1) ? $clog2(PKTS_PER_GROUP) : 1;
  localparam logic [7:0] LAST_BYTE = 8'(PKT_LEN - 1);

  rnd_state_e           state_r;
  logic [7:0]           byte_cnt_r;
  logic [PKT_CNT_W-1:0] pkt_cnt_r;
  logic [7:0]           out_data_r;
  logic                 out_sop_r;
  logic                 out_valid_r;
  logic                 sync_err_r;

  logic       accept_s;
  logic       group_start_s;
  logic       err_s;
  logic       to_hunt_s;
  logic       lfsr_stall_s;
  logic       lfsr_clear_s;
  logic [7:0] prbs_s;
  logic [7:0] data_s;

  assign in_ready     = !out_valid_r | out_ready;
  assign accept_s     = in_valid & in_ready;
  assign lfsr_stall_s = !accept_s;
  assign lfsr_clear_s = accept_s & group_start_s;

  zl_lfsr #(
    .LFSR_width     (15),
    .PRBS_width     (8),
    .LFSR_poly      (LFSR_poly),
    .LFSR_init_value(LFSR_init_value)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .stall(lfsr_stall_s),
    .clear(lfsr_clear_s),
    .prbs (prbs_s)
  );

  // Classify the incoming byte: group start, framing error, or regular payload.
  always_comb begin
    group_start_s = 1'b0;
    err_s         = 1'b0;
    to_hunt_s     = 1'b0;
    data_s        = in_data;
    if (state_r == ST_HUNT) begin
      group_start_s = in_sop;
    end else if (in_sop) begin
      err_s         = (byte_cnt_r != 8'd0);
      group_start_s = err_s | (pkt_cnt_r == PKT_CNT_W'(0));
    end else begin
      err_s     = (byte_cnt_r == 8'd0);
      to_hunt_s = err_s;
    end

    if (group_start_s) begin
      data_s = ~in_data;
    end else if ((state_r == ST_RUN) && !in_sop && (byte_cnt_r != 8'd0)) begin
      data_s = in_data ^ prbs_s;
    end else begin
      data_s = in_data;
    end
  end

  // FSM, packet/byte counters and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_HUNT;
      byte_cnt_r  <= 8'd0;
      pkt_cnt_r   <= PKT_CNT_W'(0);
      out_data_r  <= 8'd0;
      out_sop_r   <= 1'b0;
      out_valid_r <= 1'b0;
      sync_err_r  <= 1'b0;
    end else begin
      sync_err_r <= accept_s & err_s;
      if (in_ready) begin
        out_valid_r <= in_valid;
      end
      if (accept_s) begin
        out_data_r <= data_s;
        out_sop_r  <= in_sop;
        case (state_r)
          ST_HUNT: begin
            pkt_cnt_r <= PKT_CNT_W'(0);
            if (in_sop) begin
              state_r    <= ST_RUN;
              byte_cnt_r <= 8'd1;
            end else begin
              byte_cnt_r <= 8'd0;
            end
          end
          ST_RUN: begin
            if (group_start_s) begin
              byte_cnt_r <= 8'd1;
              pkt_cnt_r  <= PKT_CNT_W'(0);
            end else if (to_hunt_s) begin
              state_r    <= ST_HUNT;
              byte_cnt_r <= 8'd0;
              pkt_cnt_r  <= PKT_CNT_W'(0);
            end else if (byte_cnt_r == LAST_BYTE) begin
              byte_cnt_r <= 8'd0;
              pkt_cnt_r  <= pkt_cnt_r + PKT_CNT_W'(1);
            end else begin
              byte_cnt_r <= byte_cnt_r + 8'd1;
            end
          end
          default: begin
            state_r    <= ST_HUNT;
            byte_cnt_r <= 8'd0;
            pkt_cnt_r  <= PKT_CNT_W'(0);
          end
        endcase
      end
    end
  end

  assign out_data  = out_data_r;
  assign out_sop   = out_sop_r;
  assign out_valid = out_valid_r;
  assign sync_err  = sync_err_r;

endmodule
